// File: rtl/peak_report_pkg.sv
// Shared constants, frame layout and types for the peak-report framer.
package peak_report_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h504B504B;  // ASCII "PKPK"

  localparam int unsigned REPORT_W    = 256;
  localparam int unsigned CID_W       = 64;
  localparam int unsigned ENTRY_W     = REPORT_W + CID_W;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned FRAME_BEATS = 6;
  localparam int unsigned BEAT_CNT_W  = 3;

  // Low bit of each 64-bit report slice, emitted high to low on beats 2..5
  localparam int unsigned OFS_NUM_Q = 192;
  localparam int unsigned OFS_VAL_I = 128;
  localparam int unsigned OFS_VAL_Q = 64;
  localparam int unsigned OFS_IDX_Q = 0;

  // One buffered report tagged with the chirp counter at acceptance
  typedef struct packed {
    logic [CID_W-1:0]    counter_id;
    logic [REPORT_W-1:0] report;
  } pk_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BEAT = 2'd2
  } frm_state_e;

endpackage

// File: rtl/pk_report_fifo.sv
// Synchronous FIFO with registered read data and registered full/empty.
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_push/i_wdata write;
// i_pop read (o_rdata valid the cycle after); o_full/o_empty/o_count status.
module pk_report_fifo #(
  parameter int unsigned WIDTH = 320,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  // Occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_rdata <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rptr  <= r_rptr + PTR_W'(1);
        r_rdata <= r_mem[r_rptr];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/peak_report_framer.sv
// Buffers 256-bit peak reports with their counter_id and emits each as a
// 6-beat 64-bit AXI4-Stream frame: {MAGIC,seq}, counter_id, 4 report slices.
// Ports: aclk/aresetn (sync active-low); enable gates acceptance;
// s_axis_* report input (tlast ignored); counter_id sampled on accept;
// m_axis_* frame output; drop_count and seq_num status.
module peak_report_framer
  import peak_report_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          DROP_ON_FULL = 1'b1,
  parameter logic [31:0] MAGIC        = MAGIC_DEFAULT
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic [REPORT_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  input  logic [CID_W-1:0]    counter_id,
  output logic [BEAT_W-1:0]   m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic [31:0]         drop_count,
  output logic [31:0]         seq_num
);

  frm_state_e               r_state;
  frm_state_e               w_state_nxt;
  pk_entry_t                w_entry;
  pk_entry_t                r_hold;
  logic [ENTRY_W-1:0]       w_fifo_rdata;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_unused_count;
  logic                     w_unused_tlast;
  logic                     r_alive;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_pop;
  logic                     w_hs;
  logic                     w_last_hs;
  logic                     r_tvalid;
  logic [BEAT_CNT_W-1:0]    r_beat;
  logic [31:0]              r_seq;
  logic [31:0]              r_hold_seq;
  logic [31:0]              r_drop;
  logic [BEAT_W-1:0]        w_beat_data;

  assign w_unused_tlast = s_axis_tlast;

  // r_alive keeps tready low through the reset cycle itself
  assign s_axis_tready = r_alive & enable & (DROP_ON_FULL | ~w_fifo_full);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  // "full" is the registered occupancy; a same-cycle pop does not make room
  assign w_push        = w_accept & ~w_fifo_full;
  assign w_drop        = w_accept & w_fifo_full;

  assign w_entry.counter_id = counter_id;
  assign w_entry.report     = s_axis_tdata;

  pk_report_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_unused_count)
  );

  assign w_hs      = r_tvalid & m_axis_tready;
  assign w_last_hs = w_hs & (r_beat == BEAT_CNT_W'(FRAME_BEATS - 1));

  // Framer state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; the FIFO pop is issued on the edge that enters LOAD
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_BEAT;
      end
      ST_BEAT: begin
        if (w_last_hs) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Holding register, beat counter, sequence and drop counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_alive    <= 1'b0;
      r_tvalid   <= 1'b0;
      r_beat     <= '0;
      r_seq      <= '0;
      r_hold_seq <= '0;
      r_hold     <= '0;
      r_drop     <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_drop && (r_drop != 32'hFFFF_FFFF)) begin
        r_drop <= r_drop + 32'd1;
      end
      if (r_state == ST_LOAD) begin
        r_hold     <= pk_entry_t'(w_fifo_rdata);
        r_hold_seq <= r_seq;
        r_beat     <= '0;
        r_tvalid   <= 1'b1;
      end else if (w_last_hs) begin
        r_seq    <= r_seq + 32'd1;
        r_tvalid <= 1'b0;
      end else if (w_hs) begin
        r_beat <= r_beat + BEAT_CNT_W'(1);
      end
    end
  end

  // Beat payload select
  always_comb begin
    w_beat_data = '0;
    case (r_beat)
      3'd0:    w_beat_data = {MAGIC, r_hold_seq};
      3'd1:    w_beat_data = r_hold.counter_id;
      3'd2:    w_beat_data = r_hold.report[OFS_NUM_Q +: BEAT_W];
      3'd3:    w_beat_data = r_hold.report[OFS_VAL_I +: BEAT_W];
      3'd4:    w_beat_data = r_hold.report[OFS_VAL_Q +: BEAT_W];
      3'd5:    w_beat_data = r_hold.report[OFS_IDX_Q +: BEAT_W];
      default: w_beat_data = '0;
    endcase
  end

  // Data and tlast read as zero whenever no beat is offered
  assign m_axis_tdata  = r_tvalid ? w_beat_data : '0;
  assign m_axis_tlast  = r_tvalid & (r_beat == BEAT_CNT_W'(FRAME_BEATS - 1));
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tkeep  = 8'hFF;
  assign drop_count    = r_drop;
  assign seq_num       = r_seq;

endmodule
